instr_encoder: RTL
==================

// Module: instr_encoder
// PURPOSE
//  Inverse of the control-unit decoder: turns a mnemonic kind plus register and immediate fields into a
//  32-bit MIPS instruction word. Feeds instruction-memory preload and the self-checking testbench.
//  Input is a valid/ready stream. Encoded words are buffered in a FIFO and emitted with a running
//  byte address.
// PARAMETERS
//  DEPTH      4             FIFO entries (power of 2, >=2)
//  BASE_ADDR  32'h00003000  address tagged on the first emitted word
// PORTS
//  clk          in   1   system clock, rising edge
//  reset        in   1   asynchronous, active-low reset
//  flush        in   1   sync clear of FIFO contents (address counter kept)
//  in_valid     in   1   request present
//  in_ready     out  1   encoder can accept (FIFO not full)
//  in_kind      in   6   mnemonic code, KIND_* from const.v
//  in_rs        in   5   rs field
//  in_rt        in   5   rt field
//  in_rd        in   5   rd field
//  in_shamt     in   5   shift amount
//  in_imm16     in   16  immediate / branch offset
//  in_imm26     in   26  jump target index
//  out_valid    out  1   FIFO head valid
//  out_ready    in   1   consumer takes head
//  out_instr    out  32  encoded word at head
//  out_addr     out  32  address of head word
//  err_illegal  out  1   one-cycle pulse: an illegal kind was accepted
//  illegal_cnt  out  8   saturating count of illegal kinds
// BEHAVIOUR
//  Reset (reset==0, async): FIFO empty, out_valid=0, out_instr=0, out_addr=BASE_ADDR, err_illegal=0,
//   illegal_cnt=0.
//  Accept: in_valid&&in_ready at rising edge. in_ready = !full. No bypass when full: a pop in the same
//   cycle does not raise in_ready.
//  Latency: word accepted at edge N is visible at head (out_valid=1) after edge N when the FIFO was empty.
//  Pop: out_valid&&out_ready. Head advances and out_addr += 4 (mod 2^32 wrap).
//  Simultaneous push+pop with FIFO not full: both happen and the count is unchanged.
//  flush: empties FIFO and drops any same-cycle push. out_addr is not changed. flush takes priority
//   over push/pop.
//  Encoding: combinational from registered-on-accept inputs, pushed at the accepting edge. Fields an
//   instruction does not use are forced to 0, whatever the input value:
//   R-calc (addu,subu,add,sub,and,or,xor,nor,slt,sltu): op=0, rs,rt,rd, shamt=0, func.
//   shift_s (sll,srl,sra): rs=0, rt,rd,shamt. shift_v (sllv,srlv,srav): rs,rt,rd, shamt=0.
//   mult/multu/div/divu: rd=0, shamt=0. mfhi/mflo: rs=rt=0. mthi/mtlo: rt=rd=shamt=0.
//   jr: rt=rd=shamt=0. jalr: rt=0, rd (given), shamt=0.
//   I-type (ori,andi,xori,addi,addiu,slti,sltiu,loads,stores,beq,bne): op,rs,rt,imm16.
//   lui: rs=0. blez/bgtz: rt=0.
//   bltz/bgez: op=6'h01, rt=5'd0 / 5'd1 (REGIMM), rs, imm16.
//   j/jal: op, imm26. KIND_NOP: 32'h0.
//  Illegal kind (code outside the KIND_* table): handshake completes and nothing is pushed.
//   err_illegal=1 for the cycle after the edge. illegal_cnt++ saturating at 255.
//  Reset mid-stream: all queued words are lost. The address restarts at BASE_ADDR.
// STRUCTURE
//  const.v: KIND_* codes (6-bit), plus OP_*/FUNC_*/RT_bltz/RT_bgez. The existing decoder constants
//   are reused, so encoder and decoder share one table.
//  Sub-module instr_fifo (DEPTH x 32, ptrs + count, push/pop/flush). The encode mux lives in the top.
// TESTING
//  1 KIND_ADDU rs=1 rt=2 rd=3 -> out_instr 32'h00221821, out_addr 32'h00003000, valid 1 cycle after accept.
//  2 KIND_SLL rs=7 rt=3 rd=2 shamt=4 -> 32'h00031100 (rs forced 0). KIND_NOP -> 32'h00000000.
//  3 KIND_ORI rt=8 imm=16'h1234 -> 32'h34081234. KIND_LUI rs=5 rt=1 imm=16'hABCD -> 32'h3C01ABCD.
//  4 KIND_BGEZ rs=5 imm=16'hFFFF -> 32'h04A1FFFF. KIND_JAL imm26=26'h0000C00 -> 32'h0C000C00.
//  5 out_ready=0, push 5 words -> in_ready drops after 4, word 5 is held. Then pop 1 -> in_ready=1 next
//    cycle, and addresses 3000,3004,... are in order.
//  6 kind=6'h3F -> no push, err_illegal pulses 1 cycle, illegal_cnt=1. flush with 3 queued ->
//    out_valid=0 next cycle and out_addr unchanged.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared constants for the MIPS instruction encoder.
//
// Holds the mnemonic kind table (the same codes the control-unit decoder
// uses), the primary opcode / function / REGIMM rt values, and small
// helpers that pack the three MIPS instruction formats.
package instr_encoder_pkg;

    // Mnemonic kinds; any 6-bit code not listed here is illegal.
    typedef enum logic [5:0] {
        KIND_NOP   = 6'd0,
        KIND_ADDU  = 6'd1,
        KIND_SUBU  = 6'd2,
        KIND_ADD   = 6'd3,
        KIND_SUB   = 6'd4,
        KIND_AND   = 6'd5,
        KIND_OR    = 6'd6,
        KIND_XOR   = 6'd7,
        KIND_NOR   = 6'd8,
        KIND_SLT   = 6'd9,
        KIND_SLTU  = 6'd10,
        KIND_SLL   = 6'd11,
        KIND_SRL   = 6'd12,
        KIND_SRA   = 6'd13,
        KIND_SLLV  = 6'd14,
        KIND_SRLV  = 6'd15,
        KIND_SRAV  = 6'd16,
        KIND_MULT  = 6'd17,
        KIND_MULTU = 6'd18,
        KIND_DIV   = 6'd19,
        KIND_DIVU  = 6'd20,
        KIND_MFHI  = 6'd21,
        KIND_MFLO  = 6'd22,
        KIND_MTHI  = 6'd23,
        KIND_MTLO  = 6'd24,
        KIND_JR    = 6'd25,
        KIND_JALR  = 6'd26,
        KIND_ORI   = 6'd27,
        KIND_ANDI  = 6'd28,
        KIND_XORI  = 6'd29,
        KIND_ADDI  = 6'd30,
        KIND_ADDIU = 6'd31,
        KIND_SLTI  = 6'd32,
        KIND_SLTIU = 6'd33,
        KIND_LW    = 6'd34,
        KIND_LH    = 6'd35,
        KIND_LHU   = 6'd36,
        KIND_LB    = 6'd37,
        KIND_LBU   = 6'd38,
        KIND_SW    = 6'd39,
        KIND_SH    = 6'd40,
        KIND_SB    = 6'd41,
        KIND_BEQ   = 6'd42,
        KIND_BNE   = 6'd43,
        KIND_LUI   = 6'd44,
        KIND_BLEZ  = 6'd45,
        KIND_BGTZ  = 6'd46,
        KIND_BLTZ  = 6'd47,
        KIND_BGEZ  = 6'd48,
        KIND_J     = 6'd49,
        KIND_JAL   = 6'd50
    } kind_e;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;

    // SPECIAL function codes
    localparam logic [5:0] FUNC_SLL   = 6'h00;
    localparam logic [5:0] FUNC_SRL   = 6'h02;
    localparam logic [5:0] FUNC_SRA   = 6'h03;
    localparam logic [5:0] FUNC_SLLV  = 6'h04;
    localparam logic [5:0] FUNC_SRLV  = 6'h06;
    localparam logic [5:0] FUNC_SRAV  = 6'h07;
    localparam logic [5:0] FUNC_JR    = 6'h08;
    localparam logic [5:0] FUNC_JALR  = 6'h09;
    localparam logic [5:0] FUNC_MFHI  = 6'h10;
    localparam logic [5:0] FUNC_MTHI  = 6'h11;
    localparam logic [5:0] FUNC_MFLO  = 6'h12;
    localparam logic [5:0] FUNC_MTLO  = 6'h13;
    localparam logic [5:0] FUNC_MULT  = 6'h18;
    localparam logic [5:0] FUNC_MULTU = 6'h19;
    localparam logic [5:0] FUNC_DIV   = 6'h1A;
    localparam logic [5:0] FUNC_DIVU  = 6'h1B;
    localparam logic [5:0] FUNC_ADD   = 6'h20;
    localparam logic [5:0] FUNC_ADDU  = 6'h21;
    localparam logic [5:0] FUNC_SUB   = 6'h22;
    localparam logic [5:0] FUNC_SUBU  = 6'h23;
    localparam logic [5:0] FUNC_AND   = 6'h24;
    localparam logic [5:0] FUNC_OR    = 6'h25;
    localparam logic [5:0] FUNC_XOR   = 6'h26;
    localparam logic [5:0] FUNC_NOR   = 6'h27;
    localparam logic [5:0] FUNC_SLT   = 6'h2A;
    localparam logic [5:0] FUNC_SLTU  = 6'h2B;

    // REGIMM selectors carried in the rt field
    localparam logic [4:0] RT_BLTZ = 5'd0;
    localparam logic [4:0] RT_BGEZ = 5'd1;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] shamt,
                                           input logic [5:0] func);
        return {OP_SPECIAL, rs, rt, rd, shamt, func};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm16);
        return {op, rs, rt, imm16};
    endfunction

    function automatic logic [31:0] j_word(input logic [5:0] op, input logic [25:0] imm26);
        return {op, imm26};
    endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// instr_fifo: DEPTH x WIDTH synchronous FIFO for encoded instruction words.
//
// Ports:
//   clk, reset  clock (rising edge) / asynchronous active-low reset
//   flush       synchronous clear; wins over push and pop
//   push, wdata write request and data (ignored when full)
//   pop         advance head (ignored when empty)
//   rdata       word at head (meaningful only when !empty)
//   full, empty occupancy flags
module instr_fifo
    import instr_encoder_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; stale entries are never visible past the count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: builds 32-bit MIPS instruction words from a mnemonic kind
// plus register / immediate fields and streams them out through a FIFO,
// tagging each emitted word with a running byte address.
//
// Ports:
//   clk, reset            clock / asynchronous active-low reset
//   flush                 empty the FIFO (address counter kept)
//   in_valid, in_ready    request handshake (in_ready = FIFO not full)
//   in_kind               mnemonic kind code (kind_e)
//   in_rs/rt/rd/shamt     register and shift fields
//   in_imm16, in_imm26    immediate / branch offset, jump index
//   out_valid, out_ready  head-of-FIFO handshake
//   out_instr, out_addr   head word (0 when empty) and its byte address
//   err_illegal           one-cycle pulse after an illegal kind is accepted
//   illegal_cnt           saturating count of accepted illegal kinds
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_kind,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [15:0] in_imm16,
    input  logic [25:0] in_imm26,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err_illegal,
    output logic [7:0]  illegal_cnt
);

    logic [31:0] enc_word;
    logic        enc_legal;
    logic        accept;
    logic        push;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] fifo_rdata;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign in_ready  = !fifo_full;
    assign accept    = in_valid && in_ready;
    assign push      = accept && enc_legal;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready && !flush;
    assign out_instr = out_valid ? fifo_rdata : 32'h0;

    // Encode mux: unused fields are tied to zero regardless of input.
    always_comb begin
        enc_word  = 32'h0;
        enc_legal = 1'b1;
        case (kind_e'(in_kind))
            KIND_NOP:   enc_word = 32'h0;
            KIND_ADDU:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, FUNC_ADDU);
            KIND_SUBU:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, FUNC_SUBU);
            KIND_ADD:   enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, FUNC_ADD);
            KIND_SUB:   enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, FUNC_SUB);
            KIND_AND:   enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, FUNC_AND);
            KIND_OR:    enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, FUNC_OR);
            KIND_XOR:   enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, FUNC_XOR);
            KIND_NOR:   enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, FUNC_NOR);
            KIND_SLT:   enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, FUNC_SLT);
            KIND_SLTU:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, FUNC_SLTU);
            KIND_SLL:   enc_word = r_word(5'd0, in_rt, in_rd, in_shamt, FUNC_SLL);
            KIND_SRL:   enc_word = r_word(5'd0, in_rt, in_rd, in_shamt, FUNC_SRL);
            KIND_SRA:   enc_word = r_word(5'd0, in_rt, in_rd, in_shamt, FUNC_SRA);
            KIND_SLLV:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, FUNC_SLLV);
            KIND_SRLV:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, FUNC_SRLV);
            KIND_SRAV:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, FUNC_SRAV);
            KIND_MULT:  enc_word = r_word(in_rs, in_rt, 5'd0, 5'd0, FUNC_MULT);
            KIND_MULTU: enc_word = r_word(in_rs, in_rt, 5'd0, 5'd0, FUNC_MULTU);
            KIND_DIV:   enc_word = r_word(in_rs, in_rt, 5'd0, 5'd0, FUNC_DIV);
            KIND_DIVU:  enc_word = r_word(in_rs, in_rt, 5'd0, 5'd0, FUNC_DIVU);
            KIND_MFHI:  enc_word = r_word(5'd0, 5'd0, in_rd, 5'd0, FUNC_MFHI);
            KIND_MFLO:  enc_word = r_word(5'd0, 5'd0, in_rd, 5'd0, FUNC_MFLO);
            KIND_MTHI:  enc_word = r_word(in_rs, 5'd0, 5'd0, 5'd0, FUNC_MTHI);
            KIND_MTLO:  enc_word = r_word(in_rs, 5'd0, 5'd0, 5'd0, FUNC_MTLO);
            KIND_JR:    enc_word = r_word(in_rs, 5'd0, 5'd0, 5'd0, FUNC_JR);
            KIND_JALR:  enc_word = r_word(in_rs, 5'd0, in_rd, 5'd0, FUNC_JALR);
            KIND_ORI:   enc_word = i_word(OP_ORI,   in_rs, in_rt, in_imm16);
            KIND_ANDI:  enc_word = i_word(OP_ANDI,  in_rs, in_rt, in_imm16);
            KIND_XORI:  enc_word = i_word(OP_XORI,  in_rs, in_rt, in_imm16);
            KIND_ADDI:  enc_word = i_word(OP_ADDI,  in_rs, in_rt, in_imm16);
            KIND_ADDIU: enc_word = i_word(OP_ADDIU, in_rs, in_rt, in_imm16);
            KIND_SLTI:  enc_word = i_word(OP_SLTI,  in_rs, in_rt, in_imm16);
            KIND_SLTIU: enc_word = i_word(OP_SLTIU, in_rs, in_rt, in_imm16);
            KIND_LW:    enc_word = i_word(OP_LW,    in_rs, in_rt, in_imm16);
            KIND_LH:    enc_word = i_word(OP_LH,    in_rs, in_rt, in_imm16);
            KIND_LHU:   enc_word = i_word(OP_LHU,   in_rs, in_rt, in_imm16);
            KIND_LB:    enc_word = i_word(OP_LB,    in_rs, in_rt, in_imm16);
            KIND_LBU:   enc_word = i_word(OP_LBU,   in_rs, in_rt, in_imm16);
            KIND_SW:    enc_word = i_word(OP_SW,    in_rs, in_rt, in_imm16);
            KIND_SH:    enc_word = i_word(OP_SH,    in_rs, in_rt, in_imm16);
            KIND_SB:    enc_word = i_word(OP_SB,    in_rs, in_rt, in_imm16);
            KIND_BEQ:   enc_word = i_word(OP_BEQ,   in_rs, in_rt, in_imm16);
            KIND_BNE:   enc_word = i_word(OP_BNE,   in_rs, in_rt, in_imm16);
            KIND_LUI:   enc_word = i_word(OP_LUI,   5'd0,  in_rt, in_imm16);
            KIND_BLEZ:  enc_word = i_word(OP_BLEZ,  in_rs, 5'd0,  in_imm16);
            KIND_BGTZ:  enc_word = i_word(OP_BGTZ,  in_rs, 5'd0,  in_imm16);
            // REGIMM branches select the condition through the rt field.
            KIND_BLTZ:  enc_word = i_word(OP_REGIMM, in_rs, RT_BLTZ, in_imm16);
            KIND_BGEZ:  enc_word = i_word(OP_REGIMM, in_rs, RT_BGEZ, in_imm16);
            KIND_J:     enc_word = j_word(OP_J,   in_imm26);
            KIND_JAL:   enc_word = j_word(OP_JAL, in_imm26);
            default:    enc_legal = 1'b0;
        endcase
    end

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata (enc_word),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Illegal kinds still complete the handshake; they are only counted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_addr    <= BASE_ADDR;
            err_illegal <= 1'b0;
            illegal_cnt <= 8'd0;
        end else begin
            err_illegal <= accept && !enc_legal;
            if (accept && !enc_legal) illegal_cnt <= sat_inc(illegal_cnt);
            if (pop) out_addr <= out_addr + 32'd4;
        end
    end

endmodule
